// File: rtl/byte_serializer_pkg.sv
// Shared definitions for the serializer / sequence-detector family.
package byte_serializer_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_e;

endpackage

// File: rtl/byte_serializer_if.sv
// Parallel-in handshake plus serial-out stream of the byte serializer.
interface byte_serializer_if
    import byte_serializer_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);

    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             x;
    logic             x_valid;
    logic             busy;

    modport master (
        output in_data, in_valid,
        input  in_ready, x, x_valid, busy
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, x, x_valid, busy
    );

endinterface

// File: rtl/byte_serializer.sv
// Parallel-to-serial converter with a one-word hold buffer so consecutive
// words stream without gaps; feeds a downstream sequence detector.
module byte_serializer
    import byte_serializer_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    byte_serializer_if.slave   bus
);

    localparam int unsigned    CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    ser_state_e       state_q, state_n;
    logic [WIDTH-1:0] shreg_q, shreg_n;
    logic [WIDTH-1:0] hold_q, hold_n;
    logic             hold_full_q, hold_full_n;
    logic [CW-1:0]    cnt_q, cnt_n;

    logic             x_q, x_n;
    logic             x_valid_q, x_valid_n;
    logic             busy_q, busy_n;
    logic             in_ready_q, in_ready_n;

    logic             accept;
    logic             last;
    logic [WIDTH-1:0] shifted;
    logic             head_n;

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_n     = state_q;
        shreg_n     = shreg_q;
        hold_n      = hold_q;
        hold_full_n = hold_full_q;
        cnt_n       = cnt_q;

        accept = bus.in_valid && in_ready_q;
        last   = (cnt_q == LAST);

        if (MSB_FIRST) begin
            shifted = {shreg_q[WIDTH-2:0], 1'b0};
        end else begin
            shifted = {1'b0, shreg_q[WIDTH-1:1]};
        end

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    shreg_n = bus.in_data;
                    cnt_n   = '0;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (last) begin
                    cnt_n = '0;
                    // Refill from hold first, else bypass a word arriving now
                    if (hold_full_q) begin
                        shreg_n     = hold_q;
                        hold_full_n = 1'b0;
                    end else if (accept) begin
                        shreg_n = bus.in_data;
                    end else begin
                        shreg_n = '0;
                        state_n = IDLE;
                    end
                end else begin
                    shreg_n = shifted;
                    cnt_n   = cnt_q + CW'(1);
                    if (accept) begin
                        hold_n      = bus.in_data;
                        hold_full_n = 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        head_n     = MSB_FIRST ? shreg_n[WIDTH-1] : shreg_n[0];
        x_valid_n  = (state_n == SHIFT);
        x_n        = x_valid_n && head_n;
        busy_n     = (state_n == SHIFT) || hold_full_n;
        in_ready_n = !hold_full_n;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            cnt_q       <= '0;
            x_q         <= 1'b0;
            x_valid_q   <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_n;
            shreg_q     <= shreg_n;
            hold_q      <= hold_n;
            hold_full_q <= hold_full_n;
            cnt_q       <= cnt_n;
            x_q         <= x_n;
            x_valid_q   <= x_valid_n;
            busy_q      <= busy_n;
            in_ready_q  <= in_ready_n;
        end
    end

    assign bus.x        = x_q;
    assign bus.x_valid  = x_valid_q;
    assign bus.busy     = busy_q;
    assign bus.in_ready = in_ready_q;

endmodule

// File: tb/tb_byte_serializer.sv
// Directed self-checking bench for byte_serializer (MSB-first and LSB-first instances).
module tb_byte_serializer;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    byte_serializer_if #(.WIDTH(8)) bus_m ();
    byte_serializer_if #(.WIDTH(8)) bus_l ();

    byte_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_m)
    );

    byte_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        reset          = 1'b1;
        bus_m.in_valid = 1'b0;
        bus_m.in_data  = 8'h00;
        bus_l.in_valid = 1'b0;
        bus_l.in_data  = 8'h00;
        repeat (3) @(negedge clk);
        n_cmp++; if (bus_m.x !== 1'b0)        begin n_err++; $display("FAIL reset_msb_x: got %b want 0", bus_m.x); end
        n_cmp++; if (bus_m.x_valid !== 1'b0)  begin n_err++; $display("FAIL reset_msb_x_valid: got %b want 0", bus_m.x_valid); end
        n_cmp++; if (bus_m.busy !== 1'b0)     begin n_err++; $display("FAIL reset_msb_busy: got %b want 0", bus_m.busy); end
        n_cmp++; if (bus_m.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_msb_in_ready: got %b want 1", bus_m.in_ready); end
        n_cmp++; if (bus_l.x_valid !== 1'b0)  begin n_err++; $display("FAIL reset_lsb_x_valid: got %b want 0", bus_l.x_valid); end
        n_cmp++; if (bus_l.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_lsb_in_ready: got %b want 1", bus_l.in_ready); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_word();
        logic [7:0] w;
        w = 8'hB0;
        bus_m.in_data  = w;
        bus_m.in_valid = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            bus_m.in_valid = 1'b0;
            if (k <= 8) begin
                n_cmp++; if (bus_m.x !== w[8-k])      begin n_err++; $display("FAIL single_x bit %0d: got %b want %b", k, bus_m.x, w[8-k]); end
                n_cmp++; if (bus_m.x_valid !== 1'b1)  begin n_err++; $display("FAIL single_x_valid bit %0d: got %b want 1", k, bus_m.x_valid); end
            end else begin
                n_cmp++; if (bus_m.x_valid !== 1'b0)  begin n_err++; $display("FAIL single_end_x_valid: got %b want 0", bus_m.x_valid); end
                n_cmp++; if (bus_m.x !== 1'b0)        begin n_err++; $display("FAIL single_end_x: got %b want 0", bus_m.x); end
                n_cmp++; if (bus_m.busy !== 1'b0)     begin n_err++; $display("FAIL single_end_busy: got %b want 0", bus_m.busy); end
                n_cmp++; if (bus_m.in_ready !== 1'b1) begin n_err++; $display("FAIL single_end_in_ready: got %b want 1", bus_m.in_ready); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  words [2];
        logic [15:0] stream;
        logic        exp_x, exp_v, exp_rdy;
        int          idx;
        words[0] = 8'h0B;
        words[1] = 8'hB0;
        stream   = 16'h0BB0;
        idx      = 0;
        for (int k = 0; k <= 17; k++) begin
            if (k >= 1) begin
                exp_v   = (k <= 16);
                exp_x   = exp_v ? stream[16-k] : 1'b0;
                exp_rdy = (k == 1) || (k >= 9);
                n_cmp++; if (bus_m.x !== exp_x)          begin n_err++; $display("FAIL b2b_x cycle %0d: got %b want %b", k, bus_m.x, exp_x); end
                n_cmp++; if (bus_m.x_valid !== exp_v)    begin n_err++; $display("FAIL b2b_x_valid cycle %0d: got %b want %b", k, bus_m.x_valid, exp_v); end
                n_cmp++; if (bus_m.in_ready !== exp_rdy) begin n_err++; $display("FAIL b2b_in_ready cycle %0d: got %b want %b", k, bus_m.in_ready, exp_rdy); end
                n_cmp++; if (bus_m.busy !== exp_v)       begin n_err++; $display("FAIL b2b_busy cycle %0d: got %b want %b", k, bus_m.busy, exp_v); end
            end
            if (idx < 2) begin
                bus_m.in_valid = 1'b1;
                bus_m.in_data  = words[idx];
                if (bus_m.in_ready) idx++;
            end else begin
                bus_m.in_valid = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_bypass();
        logic [15:0] stream;
        logic        exp_x, exp_v;
        stream = 16'h0BFF;
        for (int k = 0; k <= 17; k++) begin
            if (k >= 1) begin
                exp_v = (k <= 16);
                exp_x = exp_v ? stream[16-k] : 1'b0;
                n_cmp++; if (bus_m.x !== exp_x)        begin n_err++; $display("FAIL bypass_x cycle %0d: got %b want %b", k, bus_m.x, exp_x); end
                n_cmp++; if (bus_m.x_valid !== exp_v)  begin n_err++; $display("FAIL bypass_x_valid cycle %0d: got %b want %b", k, bus_m.x_valid, exp_v); end
                n_cmp++; if (bus_m.in_ready !== 1'b1)  begin n_err++; $display("FAIL bypass_in_ready cycle %0d: got %b want 1", k, bus_m.in_ready); end
            end
            bus_m.in_valid = (k == 0) || (k == 8);
            bus_m.in_data  = (k == 8) ? 8'hFF : 8'h0B;
            @(negedge clk);
        end
    endtask

    task automatic test_lsb_order();
        logic [7:0] w;
        w = 8'h0D;
        bus_l.in_data  = w;
        bus_l.in_valid = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            bus_l.in_valid = 1'b0;
            if (k <= 8) begin
                n_cmp++; if (bus_l.x !== w[k-1])     begin n_err++; $display("FAIL lsb_x bit %0d: got %b want %b", k, bus_l.x, w[k-1]); end
                n_cmp++; if (bus_l.x_valid !== 1'b1) begin n_err++; $display("FAIL lsb_x_valid bit %0d: got %b want 1", k, bus_l.x_valid); end
            end else begin
                n_cmp++; if (bus_l.x_valid !== 1'b0) begin n_err++; $display("FAIL lsb_end_x_valid: got %b want 0", bus_l.x_valid); end
            end
        end
    endtask

    task automatic test_reset_mid_word();
        logic [2:0] first_bits;
        first_bits = 3'b101;
        bus_m.in_valid = 1'b1;
        bus_m.in_data  = 8'hB0;
        @(negedge clk);
        bus_m.in_data  = 8'h0B;
        for (int k = 1; k <= 3; k++) begin
            n_cmp++; if (bus_m.x !== first_bits[3-k]) begin n_err++; $display("FAIL midrst_x bit %0d: got %b want %b", k, bus_m.x, first_bits[3-k]); end
            if (k == 1) begin
                @(negedge clk);
                bus_m.in_valid = 1'b0;
            end else if (k == 2) begin
                @(negedge clk);
            end
        end
        n_cmp++; if (bus_m.in_ready !== 1'b0) begin n_err++; $display("FAIL midrst_hold_full: got in_ready %b want 0", bus_m.in_ready); end
        reset          = 1'b1;
        bus_m.in_valid = 1'b1;
        bus_m.in_data  = 8'hFF;
        @(negedge clk);
        reset          = 1'b0;
        bus_m.in_valid = 1'b0;
        n_cmp++; if (bus_m.x !== 1'b0)        begin n_err++; $display("FAIL midrst_x: got %b want 0", bus_m.x); end
        n_cmp++; if (bus_m.x_valid !== 1'b0)  begin n_err++; $display("FAIL midrst_x_valid: got %b want 0", bus_m.x_valid); end
        n_cmp++; if (bus_m.busy !== 1'b0)     begin n_err++; $display("FAIL midrst_busy: got %b want 0", bus_m.busy); end
        n_cmp++; if (bus_m.in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_in_ready: got %b want 1", bus_m.in_ready); end
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            n_cmp++; if (bus_m.x_valid !== 1'b0) begin n_err++; $display("FAIL midrst_residual cycle %0d: got x_valid %b want 0", k, bus_m.x_valid); end
        end
    endtask

    // Reference overlapping "1011" detector driven by the serial stream
    task automatic test_detector_chain();
        logic [7:0] words [2];
        logic [3:0] hist;
        int         idx, bitno, n_det;
        int         det_at [2];
        words[0]  = 8'h0B;
        words[1]  = 8'hB0;
        hist      = 4'b0000;
        idx       = 0;
        bitno     = 0;
        n_det     = 0;
        det_at[0] = 0;
        det_at[1] = 0;
        for (int k = 0; k <= 20; k++) begin
            if (k >= 1 && bus_m.x_valid === 1'b1) begin
                bitno++;
                hist = {hist[2:0], bus_m.x};
                if (hist == 4'b1011) begin
                    if (n_det < 2) det_at[n_det] = bitno;
                    n_det++;
                end
            end
            if (idx < 2) begin
                bus_m.in_valid = 1'b1;
                bus_m.in_data  = words[idx];
                if (bus_m.in_ready) idx++;
            end else begin
                bus_m.in_valid = 1'b0;
            end
            @(negedge clk);
        end
        n_cmp++; if (bitno !== 16)    begin n_err++; $display("FAIL chain_bit_count: got %0d want 16", bitno); end
        n_cmp++; if (n_det !== 2)     begin n_err++; $display("FAIL chain_detect_count: got %0d want 2", n_det); end
        n_cmp++; if (det_at[0] !== 8) begin n_err++; $display("FAIL chain_first_detect: got bit %0d want 8", det_at[0]); end
        n_cmp++; if (det_at[1] !== 12) begin n_err++; $display("FAIL chain_second_detect: got bit %0d want 12", det_at[1]); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_bypass();
        test_lsb_order();
        test_reset_mid_word();
        test_detector_chain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
